// File: rtl/cpu_mem_bridge.sv
// Bridges the core's fetch and load/store channels onto one single-port SRAM.
// One access in flight; data requests take priority over instruction fetches.
module cpu_mem_bridge #(
  parameter int ADDR_WIDTH  = 14,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           PC,
  input  logic                  Inst_Req_Valid,
  output logic                  Inst_Req_Ack,
  output logic [31:0]           Instruction,
  output logic                  Inst_Valid,
  input  logic                  Inst_Ack,
  input  logic [31:0]           Address,
  input  logic                  MemWrite,
  input  logic [31:0]           Write_data,
  input  logic [3:0]            Write_strb,
  input  logic                  MemRead,
  output logic                  Mem_Req_Ack,
  output logic [31:0]           Read_data,
  output logic                  Read_data_Valid,
  input  logic                  Read_data_Ack,
  output logic                  sram_en,
  output logic [3:0]            sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    K_WR,
    K_DRD,
    K_IRD
  } kind_t;

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  state_t                state_q, state_d;
  kind_t                 kind_q, kind_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            strb_q, strb_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           inst_q, rdat_q;
  logic                  cap;

  logic unused_addr;
  assign unused_addr = ^{PC[31:ADDR_WIDTH+2], PC[1:0],
                         Address[31:ADDR_WIDTH+2], Address[1:0]};

  assign sram_addr   = addr_q;
  assign Instruction = inst_q;
  assign Read_data   = rdat_q;

  // Last wait cycle: SRAM output is valid now
  assign cap = (state_q == S_WAIT) && (cnt_q == 4'd1);

  always_comb begin
    state_d         = state_q;
    kind_d          = kind_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    strb_d          = strb_q;
    cnt_d           = cnt_q;
    Mem_Req_Ack     = 1'b0;
    Inst_Req_Ack    = 1'b0;
    sram_en         = 1'b0;
    sram_wen        = 4'd0;
    sram_wdata      = 32'd0;
    Inst_Valid      = 1'b0;
    Read_data_Valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rst) begin
          if (MemWrite || MemRead) begin
            Mem_Req_Ack = 1'b1;
            addr_d      = Address[ADDR_WIDTH+1:2];
            wdata_d     = Write_data;
            strb_d      = Write_strb;
            kind_d      = MemWrite ? K_WR : K_DRD;
            state_d     = S_ISSUE;
          end else if (Inst_Req_Valid) begin
            Inst_Req_Ack = 1'b1;
            addr_d       = PC[ADDR_WIDTH+1:2];
            kind_d       = K_IRD;
            state_d      = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        sram_en = 1'b1;
        if (kind_q == K_WR) begin
          sram_wen   = strb_q;
          sram_wdata = wdata_q;
          state_d    = S_IDLE;
        end else begin
          cnt_d   = LAT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP: begin
        if (kind_q == K_IRD) begin
          Inst_Valid = 1'b1;
          if (Inst_Ack) state_d = S_IDLE;
        end else begin
          Read_data_Valid = 1'b1;
          if (Read_data_Ack) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      kind_q  <= K_WR;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      strb_q  <= 4'd0;
      cnt_q   <= 4'd0;
      inst_q  <= 32'd0;
      rdat_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      cnt_q   <= cnt_d;
      if (cap && kind_q == K_IRD) inst_q <= sram_rdata;
      if (cap && kind_q == K_DRD) rdat_q <= sram_rdata;
    end
  end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed bench: three bridges (latency 1, 4, 3), each with its own SRAM model.
// Instance 0 covers reset/fetch/strobes/arbitration, 1 delayed ack, 2 reset mid-wait.
module tb_cpu_mem_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic        rst     [3];
  logic [31:0] pc      [3];
  logic        irv     [3];
  logic        ira     [3];
  logic [31:0] ins     [3];
  logic        iv      [3];
  logic        iack    [3];
  logic [31:0] addr    [3];
  logic        mw      [3];
  logic [31:0] wd      [3];
  logic [3:0]  ws      [3];
  logic        mr      [3];
  logic        mra     [3];
  logic [31:0] rd      [3];
  logic        rdv     [3];
  logic        rda     [3];
  logic        s_en    [3];
  logic [3:0]  s_wen   [3];
  logic [9:0]  s_addr  [3];
  logic [31:0] s_wdata [3];
  logic [31:0] s_rdata [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 4 : 3;
    logic [31:0] mem  [1024];
    logic [31:0] pipe [LAT];

    cpu_mem_bridge #(
      .ADDR_WIDTH (10),
      .MEM_LATENCY(LAT)
    ) u_dut (
      .clk            (clk),
      .rst            (rst[g]),
      .PC             (pc[g]),
      .Inst_Req_Valid (irv[g]),
      .Inst_Req_Ack   (ira[g]),
      .Instruction    (ins[g]),
      .Inst_Valid     (iv[g]),
      .Inst_Ack       (iack[g]),
      .Address        (addr[g]),
      .MemWrite       (mw[g]),
      .Write_data     (wd[g]),
      .Write_strb     (ws[g]),
      .MemRead        (mr[g]),
      .Mem_Req_Ack    (mra[g]),
      .Read_data      (rd[g]),
      .Read_data_Valid(rdv[g]),
      .Read_data_Ack  (rda[g]),
      .sram_en        (s_en[g]),
      .sram_wen       (s_wen[g]),
      .sram_addr      (s_addr[g]),
      .sram_wdata     (s_wdata[g]),
      .sram_rdata     (s_rdata[g])
    );

    always @(posedge clk) begin
      if (s_en[g]) begin
        if (s_wen[g] == 4'd0) pipe[0] <= mem[s_addr[g]];
        for (int b = 0; b < 4; b++)
          if (s_wen[g][b]) mem[s_addr[g]][8*b +: 8] <= s_wdata[g][8*b +: 8];
      end
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end

    assign s_rdata[g] = pipe[LAT-1];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input int i, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    int k = 0;
    addr[i] = a; wd[i] = d; ws[i] = s; mw[i] = 1'b1;
    @(negedge clk);
    while (mra[i] !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("st_ack", mra[i], 1);
    tick();
    mw[i] = 1'b0; wd[i] = 0; ws[i] = 0;
    @(negedge clk);
    chk("st_en", s_en[i], 1);
    chk("st_wen", s_wen[i], s);
    chk("st_wdata", s_wdata[i], d);
    tick();
  endtask

  task automatic load(input int i, input logic [31:0] a,
                      input logic [31:0] exp, input int lat);
    int k = 0;
    addr[i] = a; mr[i] = 1'b1;
    @(negedge clk);
    while (mra[i] !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("ld_ack", mra[i], 1);
    tick();
    mr[i] = 1'b0;
    @(negedge clk);
    k = 1;
    chk("ld_en", s_en[i], 1);
    chk("ld_wen", s_wen[i], 0);
    chk("ld_addr", s_addr[i], a[11:2]);
    while (rdv[i] !== 1'b1 && k < 40) begin
      tick();
      @(negedge clk);
      k++;
    end
    chk("ld_lat", k, lat + 2);
    chk("ld_data", rd[i], exp);
    rda[i] = 1'b1;
    tick();
    rda[i] = 1'b0;
    @(negedge clk);
    chk("ld_drop", rdv[i], 0);
    tick();
  endtask

  task automatic fetch(input int i, input logic [31:0] a,
                       input logic [31:0] exp, input int lat);
    int k = 0;
    pc[i] = a; irv[i] = 1'b1;
    @(negedge clk);
    while (ira[i] !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("if_ack", ira[i], 1);
    tick();
    irv[i] = 1'b0;
    @(negedge clk);
    k = 1;
    chk("if_en", s_en[i], 1);
    chk("if_addr", s_addr[i], a[11:2]);
    while (iv[i] !== 1'b1 && k < 40) begin
      tick();
      @(negedge clk);
      k++;
    end
    chk("if_lat", k, lat + 2);
    chk("if_data", ins[i], exp);
    iack[i] = 1'b1;
    tick();
    iack[i] = 1'b0;
    @(negedge clk);
    chk("if_drop", iv[i], 0);
    tick();
  endtask

  initial begin
    int k;
    int bad;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; pc[i] = 0; irv[i] = 0; iack[i] = 0; addr[i] = 0;
      mw[i] = 0; wd[i] = 0; ws[i] = 0; mr[i] = 0; rda[i] = 0;
    end

    // Reset held 3 cycles with inputs toggling
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        irv[i] = ~c[0]; mw[i] = c[0]; mr[i] = 1'b1;
        iack[i] = ~c[0]; rda[i] = c[0];
        pc[i] = $urandom; addr[i] = $urandom;
        wd[i] = $urandom; ws[i] = 4'($urandom);
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk("rst_ira", ira[i], 0);
        chk("rst_mra", mra[i], 0);
        chk("rst_iv", iv[i], 0);
        chk("rst_rdv", rdv[i], 0);
        chk("rst_en", s_en[i], 0);
        chk("rst_wen", s_wen[i], 0);
        chk("rst_ins", ins[i], 0);
        chk("rst_rd", rd[i], 0);
        chk("rst_addr", s_addr[i], 0);
        chk("rst_wdata", s_wdata[i], 0);
      end
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b0; pc[i] = 0; irv[i] = 0; iack[i] = 0; addr[i] = 0;
      mw[i] = 0; wd[i] = 0; ws[i] = 0; mr[i] = 0; rda[i] = 0;
    end
    tick();

    // Fetch, latency 1, cycle-exact
    store(0, 32'h40, 32'h00A00093, 4'hF);
    pc[0] = 32'h40; irv[0] = 1'b1;
    @(negedge clk);
    chk("f_ack_T", ira[0], 1);
    chk("f_mra_T", mra[0], 0);
    tick();
    irv[0] = 1'b0;
    @(negedge clk);
    chk("f_en_T1", s_en[0], 1);
    chk("f_addr_T1", s_addr[0], 32'h10);
    chk("f_wen_T1", s_wen[0], 0);
    chk("f_ack_T1", ira[0], 0);
    tick();
    @(negedge clk);
    chk("f_iv_T2", iv[0], 0);
    chk("f_en_T2", s_en[0], 0);
    tick();
    @(negedge clk);
    chk("f_iv_T3", iv[0], 1);
    chk("f_ins_T3", ins[0], 32'h00A00093);
    tick();
    @(negedge clk);
    chk("f_iv_T4", iv[0], 1);
    tick();
    iack[0] = 1'b1;
    @(negedge clk);
    chk("f_iv_T5", iv[0], 1);
    tick();
    iack[0] = 1'b0;
    @(negedge clk);
    chk("f_iv_T6", iv[0], 0);
    chk("f_ins_T6", ins[0], 32'h00A00093);
    tick();

    // Byte strobes, then read back directly and through an aliased address
    store(0, 32'h104, 32'h11223344, 4'hF);
    store(0, 32'h104, 32'hAABBCCDD, 4'b0101);
    @(negedge clk);
    chk("idle_wdata", s_wdata[0], 0);
    chk("idle_en", s_en[0], 0);
    tick();
    load(0, 32'h104, 32'h11BB33DD, 1);
    load(0, 32'h1104, 32'h11BB33DD, 1);

    // Simultaneous fetch and load: the load wins
    pc[0] = 32'h40; irv[0] = 1'b1; addr[0] = 32'h104; mr[0] = 1'b1;
    @(negedge clk);
    chk("arb_mra", mra[0], 1);
    chk("arb_ira", ira[0], 0);
    tick();
    mr[0] = 1'b0;
    k = 1; bad = 0;
    @(negedge clk);
    while (rdv[0] !== 1'b1 && k < 40) begin
      if (ira[0] !== 1'b0) bad++;
      tick();
      @(negedge clk);
      k++;
    end
    if (ira[0] !== 1'b0) bad++;
    chk("arb_ira_busy", bad, 0);
    chk("arb_lat", k, 3);
    chk("arb_rd", rd[0], 32'h11BB33DD);
    chk("arb_iv", iv[0], 0);
    rda[0] = 1'b1;
    tick();
    rda[0] = 1'b0;
    @(negedge clk);
    chk("arb_rdv_drop", rdv[0], 0);
    chk("arb_ira_R1", ira[0], 1);
    tick();
    irv[0] = 1'b0;
    @(negedge clk);
    chk("arb_f_en", s_en[0], 1);
    chk("arb_f_addr", s_addr[0], 32'h10);
    k = 1;
    while (iv[0] !== 1'b1 && k < 40) begin
      tick();
      @(negedge clk);
      k++;
    end
    chk("arb_f_lat", k, 3);
    chk("arb_f_ins", ins[0], 32'h00A00093);
    iack[0] = 1'b1;
    tick();
    iack[0] = 1'b0;
    @(negedge clk);
    chk("arb_f_drop", iv[0], 0);
    tick();

    // Latency 4, ack held off 10 cycles, stray Inst_Ack pulses
    store(1, 32'h200, 32'hCAFEF00D, 4'hF);
    addr[1] = 32'h200; mr[1] = 1'b1;
    @(negedge clk);
    chk("dly_ack", mra[1], 1);
    tick();
    mr[1] = 1'b0;
    k = 1;
    @(negedge clk);
    while (rdv[1] !== 1'b1 && k < 40) begin
      tick();
      iack[1] = k[0];
      @(negedge clk);
      k++;
    end
    chk("dly_lat", k, 6);
    for (int c = 0; c < 10; c++) begin
      tick();
      iack[1] = ~iack[1];
      @(negedge clk);
      chk("dly_rdv", rdv[1], 1);
      chk("dly_rd", rd[1], 32'hCAFEF00D);
      chk("dly_iv", iv[1], 0);
    end
    tick();
    iack[1] = 1'b0;
    rda[1] = 1'b1;
    tick();
    rda[1] = 1'b0;
    iack[1] = 1'b1;
    @(negedge clk);
    chk("dly_drop", rdv[1], 0);
    tick();
    iack[1] = 1'b0;
    @(negedge clk);
    chk("idle_iack_iv", iv[1], 0);
    chk("idle_iack_en", s_en[1], 0);
    chk("idle_iack_ira", ira[1], 0);
    tick();

    // Latency 3, reset pulsed in the second wait cycle
    store(2, 32'h80, 32'h12345678, 4'hF);
    pc[2] = 32'h80; irv[2] = 1'b1;
    @(negedge clk);
    chk("rw_ack", ira[2], 1);
    tick();
    irv[2] = 1'b0;
    @(negedge clk);
    chk("rw_en", s_en[2], 1);
    tick();
    tick();
    rst[2] = 1'b1;
    tick();
    rst[2] = 1'b0;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (iv[2] !== 1'b0 || s_en[2] !== 1'b0) bad++;
      tick();
    end
    chk("rw_novalid", bad, 0);
    chk("rw_ins", ins[2], 0);
    fetch(2, 32'h80, 32'h12345678, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_mem_bridge.md
# cpu_mem_bridge

Memory-side bridge directly downstream of the multi-cycle RISC-V core. It terminates the core's four valid/ack channels (instruction request, instruction response, memory request, read-data response) and serves them from one single-port synchronous SRAM with fixed read latency. One access is in flight at a time; data requests win over instruction fetches.

## Interface
- `ADDR_WIDTH`, default 14: SRAM word-address bits; capacity is 2^ADDR_WIDTH 32-bit words.
- `MEM_LATENCY`, default 1: cycles from the SRAM sampling `sram_en` to `sram_rdata` being valid; legal range 1..15.
- `clk`  in  1  the single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `PC`  in  32  instruction byte address.
- `Inst_Req_Valid`  in  1  core requests an instruction fetch.
- `Inst_Req_Ack`  out  1  fetch request accepted.
- `Instruction`  out  32  fetched word.
- `Inst_Valid`  out  1  `Instruction` is valid.
- `Inst_Ack`  in  1  core takes the instruction.
- `Address`  in  32  data byte address, word-aligned by the core.
- `MemWrite`  in  1  store request.
- `Write_data`  in  32  store data, already lane-replicated.
- `Write_strb`  in  4  byte enables.
- `MemRead`  in  1  load request.
- `Mem_Req_Ack`  out  1  data request accepted.
- `Read_data`  out  32  loaded word.
- `Read_data_Valid`  out  1  `Read_data` is valid.
- `Read_data_Ack`  in  1  core takes the load data.
- `sram_en`  out  1  SRAM access enable.
- `sram_wen`  out  4  per-byte write enables; 0 means a read.
- `sram_addr`  out  ADDR_WIDTH  word address.
- `sram_wdata`  out  32  write data.
- `sram_rdata`  in  32  read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, data request present (`MemWrite|MemRead`):
  - `Mem_Req_Ack`=1 combinationally.
  - Latch `Address[ADDR_WIDTH+1:2]`, `Write_data` and `Write_strb`.
  - Latch the request kind: write if `MemWrite`, else data-read. `MemWrite` wins if both are high.
  - Go to ISSUE.
- IDLE, no data request, `Inst_Req_Valid`=1:
  - `Inst_Req_Ack`=1 combinationally.
  - Latch `PC[ADDR_WIDTH+1:2]`, kind inst-read.
  - Go to ISSUE.
- IDLE, no request: stay. Outside IDLE both request acks are 0.
- ISSUE:
  - `sram_en`=1 and `sram_addr` = latched address for exactly one cycle.
  - Write: `sram_wen` = latched strb, `sram_wdata` = latched data. Next state IDLE; no response phase.
  - Read: `sram_wen`=0. Load the latency counter with MEM_LATENCY and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the last cycle (counter = 1), register `sram_rdata` into `Instruction` (inst-read) or `Read_data` (data-read). The other response register holds its value.
  - Then go to RESP.
- RESP:
  - Raise `Inst_Valid` or `Read_data_Valid` according to the kind. The data register stays stable.
  - Hold until the matching ack is sampled high, then go to IDLE. The valid drops the cycle after the handshake.
  - Acks sampled outside RESP, and non-matching acks, are ignored. The core's idle-time `Inst_Ack` must have no effect.
- Address upper bits above ADDR_WIDTH+1 and bits [1:0] are ignored, so accesses wrap modulo capacity.
- `sram_en`, `sram_wen` and `sram_wdata` are 0 outside ISSUE. `sram_addr` holds its last value.

## Timing
- Reset values:
  - State IDLE.
  - `Inst_Valid`, `Read_data_Valid`, `sram_en`, `sram_wen` = 0.
  - `Instruction`, `Read_data`, `sram_addr`, `sram_wdata` = 0.
  - Request acks are 0 while `rst` is high.
- Reset mid-operation abandons any access next edge: state IDLE, no valid, no SRAM enable. A write still in ISSUE is dropped.
- Read latency with request handshake in cycle T:
  - ISSUE in T+1.
  - WAIT in T+2 .. T+1+MEM_LATENCY.
  - Valid first high in T+2+MEM_LATENCY.
  - For MEM_LATENCY=1 that is 3 cycles.
- Write occupies 2 cycles (accept in T, ISSUE in T+1). A new request can be acked in T+2.
- After a response handshake in cycle R, the next request can be acked in R+1.
- Back-to-back throughput: one read per MEM_LATENCY+3 cycles with zero-delay acks.

## Test plan
- Reset: hold `rst` 3 cycles with all inputs toggling -> every output 0 and no acks.
- Instruction fetch, MEM_LATENCY=1, SRAM word 0x10 = 0x00A00093, `PC`=0x40 -> `Inst_Req_Ack` in T, `sram_addr`=0x10 with `sram_en` in T+1, `Instruction`=0x00A00093 with `Inst_Valid` from T+3. `Inst_Ack` in T+5 -> valid low in T+6.
- Byte-strobe write then read: store `Address`=0x104, data 0xAABBCCDD, strb 0101 over a word holding 0x11223344 -> `sram_wen`=0101 for one cycle. A load from 0x104 then returns 0x11BB33DD.
- Simultaneous `Inst_Req_Valid` and `MemRead`, same cycle -> only `Mem_Req_Ack` high and the data read is served. The fetch is acked in the first IDLE cycle after the `Read_data_Ack` handshake.
- Delayed ack, MEM_LATENCY=4, hold `Read_data_Ack` low 10 cycles -> `Read_data_Valid` first high 6 cycles after the handshake and `Read_data` stable throughout. Stray `Inst_Ack` pulses have no effect.
- Reset mid-WAIT, with MEM_LATENCY=3 and `rst` pulsed in the second WAIT cycle -> no valid ever rises. The next fetch completes normally with the correct data.
